// File: rtl/wshb_arb_pkg.sv
// Shared types and constants for the SDRAM Wishbone arbiter.
// Holds the FSM encoding, Wishbone CTI/BTE codes and the watchdog width helper.
package wshb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  // Counter must hold timeout-1, its highest value before the abort fires.
  function automatic int wdog_w(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/wshb_rr_arbiter_rr_pick.sv
// Combinational round-robin picker with an urgent override for index 0; zero latency.
// No backpressure: the winner is a pure function of the current requests.
module rr_pick
  import wshb_arb_pkg::*;
#(
  parameter int NM = 3,
  parameter int IW = $clog2(NM)
) (
  input  logic [NM-1:0] req,
  input  logic [IW-1:0] last,
  input  logic          urgent,
  output logic [NM-1:0] win
);

  logic found;

  // Scan distance k=1..NM from the previous owner so the last winner is considered last.
  always_comb begin
    win   = '0;
    found = 1'b0;
    if (urgent && req[0]) begin
      win[0] = 1'b1;
    end else begin
      for (int k = 1; k <= NM; k++) begin
        for (int j = 0; j < NM; j++) begin
          if (!found && req[j] && (j == (int'(last) + k) % NM)) begin
            win[j] = 1'b1;
            found  = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/wshb_rr_arbiter.sv
// Round-robin Wishbone arbiter sharing one slave between NM masters; 1 cycle request to s_cyc.
// A grant lasts a whole cyc tenure; a stalled strobe is aborted with err after TIMEOUT cycles.
module wshb_rr_arbiter
  import wshb_arb_pkg::*;
#(
  parameter int NM      = 3,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic [NM-1:0]             m_cyc,
  input  logic [NM-1:0]             m_stb,
  input  logic [NM-1:0]             m_we,
  input  logic [NM-1:0][AW-1:0]     m_adr,
  input  logic [NM-1:0][DW-1:0]     m_dat_ms,
  input  logic [NM-1:0][DW/8-1:0]   m_sel,
  input  logic [NM-1:0][2:0]        m_cti,
  input  logic [NM-1:0][1:0]        m_bte,
  output logic [NM-1:0]             m_ack,
  output logic [NM-1:0]             m_err,
  output logic [NM-1:0]             m_rty,
  output logic [DW-1:0]             m_dat_sm,
  output logic                      s_cyc,
  output logic                      s_stb,
  output logic                      s_we,
  output logic [AW-1:0]             s_adr,
  output logic [DW-1:0]             s_dat_ms,
  output logic [DW/8-1:0]           s_sel,
  output logic [2:0]                s_cti,
  output logic [1:0]                s_bte,
  input  logic                      s_ack,
  input  logic                      s_err,
  input  logic                      s_rty,
  input  logic [DW-1:0]             s_dat_sm,
  input  logic                      urgent,
  output logic [NM-1:0]             grant,
  output logic [7:0]                abort_cnt
);

  localparam int IW = $clog2(NM);
  localparam int WW = wdog_w(TIMEOUT);

  arb_state_t     state, state_nxt;
  logic [IW-1:0]  own, own_nxt;
  logic [IW-1:0]  last, last_nxt;
  logic [NM-1:0]  grant_nxt;
  logic [7:0]     abort_nxt;
  logic [WW-1:0]  wdog, wdog_nxt;
  logic [NM-1:0]  win;
  logic [IW-1:0]  win_idx;
  logic           s_resp;

  rr_pick #(.NM(NM), .IW(IW)) u_pick (
    .req    (m_cyc),
    .last   (last),
    .urgent (urgent),
    .win    (win)
  );

  always_comb begin
    win_idx = '0;
    for (int j = 0; j < NM; j++) begin
      if (win[j]) win_idx = IW'(j);
    end
  end

  assign s_resp   = s_ack | s_err | s_rty;
  assign m_dat_sm = s_dat_sm;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      own       <= '0;
      last      <= IW'(NM - 1);
      grant     <= '0;
      abort_cnt <= '0;
      wdog      <= '0;
    end else begin
      state     <= state_nxt;
      own       <= own_nxt;
      last      <= last_nxt;
      grant     <= grant_nxt;
      abort_cnt <= abort_nxt;
      wdog      <= wdog_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    own_nxt   = own;
    last_nxt  = last;
    grant_nxt = grant;
    abort_nxt = abort_cnt;
    wdog_nxt  = '0;
    s_cyc     = 1'b0;
    s_stb     = 1'b0;
    s_we      = 1'b0;
    s_adr     = '0;
    s_dat_ms  = '0;
    s_sel     = '0;
    s_cti     = CTI_CLASSIC;
    s_bte     = BTE_LINEAR;
    m_ack     = '0;
    m_err     = '0;
    m_rty     = '0;
    case (state)
      IDLE: begin
        if (|m_cyc) begin
          state_nxt = GRANT;
          own_nxt   = win_idx;
          grant_nxt = win;
        end
      end
      GRANT: begin
        s_we     = m_we[own];
        s_adr    = m_adr[own];
        s_dat_ms = m_dat_ms[own];
        s_sel    = m_sel[own];
        s_cti    = m_cti[own];
        s_bte    = m_bte[own];
        if (!m_cyc[own]) begin
          state_nxt = IDLE;
          last_nxt  = own;
          grant_nxt = '0;
        end else if (m_stb[own] && !s_resp && (wdog == WW'(TIMEOUT - 1))) begin
          // A response on this same cycle would have won; only a true stall aborts.
          m_err[own] = 1'b1;
          state_nxt  = DRAIN;
          if (abort_cnt != 8'hFF) abort_nxt = abort_cnt + 8'd1;
        end else begin
          s_cyc      = 1'b1;
          s_stb      = m_stb[own];
          m_ack[own] = s_ack;
          m_err[own] = s_err;
          m_rty[own] = s_rty;
          if (m_stb[own] && !s_resp) wdog_nxt = wdog + 1'b1;
        end
      end
      DRAIN: begin
        if (!m_cyc[own]) begin
          state_nxt = IDLE;
          last_nxt  = own;
          grant_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
